// File: rtl/watch_pkg.sv
// Shared types and constants for the watch timekeeping block: field width,
// mode FSM encoding and field limits.
package watch_pkg;

    typedef logic [6:0] field_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_e;

    localparam field_t SEC_MAX    = 7'd59;
    localparam field_t MIN_MAX    = 7'd59;
    localparam field_t HOUR12_MIN = 7'd1;
    localparam field_t HOUR12_MAX = 7'd12;

    function automatic field_t wrap_inc(input field_t v, input field_t max_v);
        return (v == max_v) ? 7'd0 : v + 7'd1;
    endfunction

endpackage

// File: rtl/watch_time_core_if.sv
// Button inputs and display-side outputs of the watch time core.
interface watch_time_core_if;
    import watch_pkg::*;

    logic   Mode_Btn;
    logic   Inc_Btn;
    field_t Hours;
    field_t Minutes;
    field_t Seconds;
    logic   Blink_H;
    logic   Blink_M;
    logic   Blink_S;
    logic   Tick_1Hz;
    logic   Pm;

    modport master (
        output Mode_Btn, Inc_Btn,
        input  Hours, Minutes, Seconds, Blink_H, Blink_M, Blink_S, Tick_1Hz, Pm
    );

    modport slave (
        input  Mode_Btn, Inc_Btn,
        output Hours, Minutes, Seconds, Blink_H, Blink_M, Blink_S, Tick_1Hz, Pm
    );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detector: one-cycle pulse per press.
module btn_edge (
    input  logic Clk_50MHz,
    input  logic Reset,
    input  logic btn,
    output logic pulse
);

    logic sync_p0, sync_p1, prev_p2;

    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/watch_time_core.sv
// Watch timekeeping core: 1 Hz prescaler, H:M:S carry chain and set-mode FSM.
// Define HOUR12_EN for 12-hour counting with a PM flag.
module watch_time_core
    import watch_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int HOUR_MAX = 23
) (
    input  logic               Clk_50MHz,
    input  logic               Reset,
    watch_time_core_if.slave   io
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_SET_H = SET_H;
    localparam logic [1:0] ST_SET_M = SET_M;
    localparam logic [1:0] ST_SET_S = SET_S;

`ifdef HOUR12_EN
    localparam field_t HOUR_RST = HOUR12_MAX;
`else
    localparam field_t HOUR_RST = 7'd0;
`endif

    logic               mode_pls, inc_pls;
    logic [1:0]         state, state_nxt;
    logic [PRESC_W-1:0] presc;
    field_t             hours, minutes, seconds, hours_inc;
    logic               pm, pm_inc;
    logic               tick, blink_h, blink_m, blink_s;

    btn_edge u_mode (.Clk_50MHz(Clk_50MHz), .Reset(Reset), .btn(io.Mode_Btn), .pulse(mode_pls));
    btn_edge u_inc  (.Clk_50MHz(Clk_50MHz), .Reset(Reset), .btn(io.Inc_Btn),  .pulse(inc_pls));

    always_comb begin
        state_nxt = state;
        if (mode_pls) begin
            case (state)
                ST_RUN:   state_nxt = ST_SET_H;
                ST_SET_H: state_nxt = ST_SET_M;
                ST_SET_M: state_nxt = ST_SET_S;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    // Shared by the run-time carry and the set-mode increment.
    always_comb begin
`ifdef HOUR12_EN
        pm_inc    = pm;
        hours_inc = hours + 7'd1;
        if (hours == HOUR12_MAX)
            hours_inc = HOUR12_MIN;
        else if (hours == HOUR12_MAX - 7'd1)
            pm_inc = ~pm;
`else
        pm_inc    = 1'b0;
        hours_inc = (hours == field_t'(HOUR_MAX)) ? 7'd0 : hours + 7'd1;
`endif
    end

    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            state   <= ST_RUN;
            presc   <= '0;
            tick    <= 1'b0;
            blink_h <= 1'b0;
            blink_m <= 1'b0;
            blink_s <= 1'b0;
            hours   <= HOUR_RST;
            minutes <= 7'd0;
            seconds <= 7'd0;
            pm      <= 1'b0;
        end else begin
            state   <= state_nxt;
            tick    <= 1'b0;
            blink_h <= (state_nxt == ST_SET_H);
            blink_m <= (state_nxt == ST_SET_M);
            blink_s <= (state_nxt == ST_SET_S);

            // Leaving RUN or sitting in a set state keeps the prescaler at zero.
            if (state != ST_RUN || mode_pls) begin
                presc <= '0;
            end else if (presc == PRESC_LAST) begin
                presc   <= '0;
                tick    <= 1'b1;
                seconds <= wrap_inc(seconds, SEC_MAX);
                if (seconds == SEC_MAX) begin
                    minutes <= wrap_inc(minutes, MIN_MAX);
                    if (minutes == MIN_MAX) begin
                        hours <= hours_inc;
                        pm    <= pm_inc;
                    end
                end
            end else begin
                presc <= presc + PRESC_W'(1);
            end

            if (inc_pls && !mode_pls) begin
                case (state)
                    ST_SET_H: begin
                        hours <= hours_inc;
                        pm    <= pm_inc;
                    end
                    ST_SET_M: minutes <= wrap_inc(minutes, MIN_MAX);
                    ST_SET_S: seconds <= wrap_inc(seconds, SEC_MAX);
                    default:  ;
                endcase
            end
        end
    end

    assign io.Hours    = hours;
    assign io.Minutes  = minutes;
    assign io.Seconds  = seconds;
    assign io.Blink_H  = blink_h;
    assign io.Blink_M  = blink_m;
    assign io.Blink_S  = blink_s;
    assign io.Tick_1Hz = tick;
    assign io.Pm       = pm;

endmodule

// File: tb/tb_watch_time_core.sv
// Self-checking bench for watch_time_core with CLK_HZ = 10; expected time
// stamps are queued at stimulus time and popped on every Tick_1Hz.
module tb_watch_time_core;
    import watch_pkg::*;

    localparam int CLK_HZ = 10;

    typedef struct {
        int cyc;
        int h;
        int m;
        int s;
        int pm;
    } exp_t;

    logic Clk_50MHz = 1'b0;
    logic Reset     = 1'b1;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    exp_t sb[$];

    watch_time_core_if wif ();

    watch_time_core #(.CLK_HZ(CLK_HZ), .HOUR_MAX(23)) dut (
        .Clk_50MHz (Clk_50MHz),
        .Reset     (Reset),
        .io        (wif)
    );

    always #5 Clk_50MHz = ~Clk_50MHz;

    always @(posedge Clk_50MHz) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    always @(negedge Clk_50MHz) begin
        exp_t e;
        if (!Reset && wif.Tick_1Hz === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_tick", cyc, -1);
            end else begin
                e = sb.pop_front();
                check_val("tick_cycle", cyc, e.cyc);
                check_val("tick_hours", int'(wif.Hours), e.h);
                check_val("tick_minutes", int'(wif.Minutes), e.m);
                check_val("tick_seconds", int'(wif.Seconds), e.s);
                check_val("tick_pm", int'(wif.Pm), e.pm);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk_50MHz);
        #1;
    endtask

    task automatic press(input logic m, input logic i, output int eff);
        wif.Mode_Btn = m;
        wif.Inc_Btn  = i;
        step(3);
        eff = cyc;
        wif.Mode_Btn = 1'b0;
        wif.Inc_Btn  = 1'b0;
        step(3);
    endtask

    task automatic mode1();
        int d;
        press(1'b1, 1'b0, d);
    endtask

    task automatic inc_n(input int n);
        int d;
        repeat (n) press(1'b0, 1'b1, d);
    endtask

    task automatic push_tick(input int c, input int h, input int m, input int s, input int pm);
        sb.push_back('{c, h, m, s, pm});
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_val({tag, "_hours"}, int'(wif.Hours), h);
        check_val({tag, "_minutes"}, int'(wif.Minutes), m);
        check_val({tag, "_seconds"}, int'(wif.Seconds), s);
    endtask

    task automatic check_blink(input string tag, input int h, input int m, input int s);
        check_val({tag, "_blink_h"}, int'(wif.Blink_H), h);
        check_val({tag, "_blink_m"}, int'(wif.Blink_M), m);
        check_val({tag, "_blink_s"}, int'(wif.Blink_S), s);
    endtask

    initial begin
        int eff;
        int t0;
        int hour_rst;
`ifdef HOUR12_EN
        hour_rst = 12;
`else
        hour_rst = 0;
`endif
        wif.Mode_Btn = 1'b0;
        wif.Inc_Btn  = 1'b0;
        Reset = 1'b1;
        step(3);
        check_time("reset", hour_rst, 0, 0);
        check_blink("reset", 0, 0, 0);
        check_val("reset_tick", int'(wif.Tick_1Hz), 0);
        check_val("reset_pm", int'(wif.Pm), 0);
        Reset = 1'b0;
        t0 = cyc;

`ifdef HOUR12_EN
        // Preload 11:59:59 AM, then let one tick roll it to 12:00:00 PM.
        mode1();
        inc_n(11);
        check_val("h12_hours11", int'(wif.Hours), 11);
        check_val("h12_pm_am", int'(wif.Pm), 0);
        mode1();
        inc_n(59);
        mode1();
        inc_n(59);
        check_time("h12_preload", 11, 59, 59);
        press(1'b1, 1'b0, eff);
        push_tick(eff + 10, 12, 0, 0, 1);
        step(7);
        check_val("h12_pm_after_tick", int'(wif.Pm), 1);
        mode1();
        inc_n(1);
        check_val("h12_inc_12_to_1", int'(wif.Hours), 1);
        check_val("h12_inc_pm_kept", int'(wif.Pm), 1);
        inc_n(10);
        check_val("h12_inc_to_11", int'(wif.Hours), 11);
        inc_n(1);
        check_val("h12_inc_11_to_12", int'(wif.Hours), 12);
        check_val("h12_inc_pm_toggle", int'(wif.Pm), 0);
`else
        // Free run from reset: ticks at 10, 20, 30 cycles after release.
        push_tick(t0 + 10, 0, 0, 1, 0);
        push_tick(t0 + 20, 0, 0, 2, 0);
        push_tick(t0 + 30, 0, 0, 3, 0);
        step(30);
        check_val("run_seconds", int'(wif.Seconds), 3);
        check_blink("run", 0, 0, 0);

        // Preload 23:59:58 and watch the full rollover.
        mode1();
        check_blink("set_h", 1, 0, 0);
        inc_n(23);
        check_val("preload_hours", int'(wif.Hours), 23);
        mode1();
        check_blink("set_m", 0, 1, 0);
        inc_n(59);
        mode1();
        inc_n(55);
        check_time("preload", 23, 59, 58);
        check_blink("set_s", 0, 0, 1);
        press(1'b1, 1'b0, eff);
        push_tick(eff + 10, 23, 59, 59, 0);
        push_tick(eff + 20, 0, 0, 0, 0);
        step(17);
        check_time("rollover", 0, 0, 0);

        // Held Inc gives one increment; set increments never carry.
        mode1();
        wif.Inc_Btn = 1'b1;
        step(5);
        wif.Inc_Btn = 1'b0;
        step(3);
        check_time("inc_hold", 1, 0, 0);
        check_blink("inc_hold", 1, 0, 0);
        mode1();
        inc_n(59);
        check_val("min_59", int'(wif.Minutes), 59);
        inc_n(1);
        check_time("min_wrap", 1, 0, 0);
        mode1();
        press(1'b1, 1'b0, eff);
        push_tick(eff + 10, 1, 0, 1, 0);
        step(7);

        // Mode and Inc together: Mode wins.
        press(1'b1, 1'b1, eff);
        check_val("simul_hours", int'(wif.Hours), 1);
        check_blink("simul", 1, 0, 0);
        mode1();
        mode1();
        check_blink("simul_set_s", 0, 0, 1);
        press(1'b1, 1'b0, eff);
        check_blink("back_to_run", 0, 0, 0);
        push_tick(eff + 10, 1, 0, 2, 0);
        step(7);

        // Park in SET_M at 12:34:56 and reset there.
        mode1();
        inc_n(11);
        mode1();
        inc_n(34);
        mode1();
        inc_n(54);
        press(1'b1, 1'b0, eff);
        mode1();
        mode1();
        check_time("preset", 12, 34, 56);
        check_blink("preset", 0, 1, 0);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        check_time("mid_reset", 0, 0, 0);
        check_blink("mid_reset", 0, 0, 0);
        check_val("mid_reset_tick", int'(wif.Tick_1Hz), 0);
        t0 = cyc;
        push_tick(t0 + 10, 0, 0, 1, 0);
        step(10);
`endif

        check_val("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_time_core.md
Name: watch_time_core

Overview:
- Timekeeping and time-set controller for the digital watch.
- Derives a 1 Hz tick from the 50 MHz board clock and maintains hours, minutes and seconds as binary values 0..99-range (7 bit).
- Runs a mode FSM that lets the user set each field.
- Sits directly upstream of the two-digit display drivers: each 7-bit field feeds one driver's Digits input, and each per-field blink flag feeds that driver's Blink input.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second; the bench overrides it with a small value such as 10.
- HOUR_MAX, 23, last hour value before wrap in 24-hour mode.

Ports:
- Clk_50MHz  input  1  system clock, all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Mode_Btn  input  1  asynchronous level from the debounced Mode push-button.
- Inc_Btn  input  1  asynchronous level from the debounced Increment push-button.
- Hours  output  7  current hour, to the hours display driver.
- Minutes  output  7  current minute, 0..59.
- Seconds  output  7  current second, 0..59.
- Blink_H  output  1  high while hours are being set.
- Blink_M  output  1  high while minutes are being set.
- Blink_S  output  1  high while seconds are being set.
- Tick_1Hz  output  1  one-cycle pulse on each second advance.
- Pm  output  1  PM flag; constant 0 unless HOUR12_EN is defined.

Behaviour:
- Clock and reset: one clock, Clk_50MHz. Reset is synchronous and active-high. While Reset is high at a rising edge:
  - Hours/Minutes/Seconds = 0, Pm = 0.
  - State = RUN, prescaler = 0.
  - Tick_1Hz = 0, all Blink_* = 0, button synchronisers and edge flops cleared.
  - Reset takes priority over every other event, including mid-set operation.
- Buttons:
  - Each button passes a 2-flop synchroniser, then a rising-edge detector, giving a one-cycle press pulse.
  - A level first sampled high at edge k produces its effect at edge k+2.
  - Holding a button gives exactly one pulse; no auto-repeat.
- Prescaler:
  - Counts 0..CLK_HZ-1, in RUN only.
  - At CLK_HZ-1 it wraps to 0. On that same edge Seconds advances and Tick_1Hz is registered high for exactly one cycle.
- Carry chain (all updated on the same edge):
  - Seconds 59 -> 0 carries into Minutes.
  - Minutes 59 -> 0 carries into Hours.
  - Hours HOUR_MAX -> 0.
  - 23:59:59 -> 00:00:00 in a single edge.
- FSM states: RUN, SET_H, SET_M, SET_S.
  - A Mode pulse moves RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - In any SET_* state the prescaler is held at 0, the time is frozen and Tick_1Hz is 0.
  - Inc pulse in SET_H: Hours increments, wrapping HOUR_MAX -> 0.
  - Inc pulse in SET_M or SET_S: Minutes or Seconds increments, wrapping 59 -> 0.
  - Increments in SET_* states never carry into the next field.
  - Inc pulse in RUN is ignored.
  - Leaving SET_S for RUN: the prescaler restarts at 0, so the first Tick_1Hz occurs exactly CLK_HZ cycles after the state becomes RUN.
- Blink outputs are registered decodes of the state: Blink_H = (state==SET_H), Blink_M = (state==SET_M), Blink_S = (state==SET_S). At most one is high at any time.
- Simultaneous Mode and Inc pulses in one cycle: Mode wins and Inc is dropped.
- Output ranges: all outputs are registered and never leave their legal range, so the downstream BCD conversion is always valid.

Optional Feature:
- Macro: HOUR12_EN.
- Defined:
  - Hours counts 12,1,2,...,11; reset value is Hours = 12, Pm = 0 (12 AM).
  - Carry or Inc from 11 -> 12 toggles Pm. 12 -> 1 leaves Pm unchanged.
  - 11:59:59 AM -> 12:00:00 PM in one edge.
  - In SET_H, Inc steps through the same 12-hour sequence, including the Pm toggle.
  - HOUR_MAX is unused.
- Undefined: 24-hour behaviour as above, and Pm is tied to 0.

Decomposition:
- Shared package watch_pkg holds:
  - The FSM state enumeration (RUN, SET_H, SET_M, SET_S).
  - Constants SEC_MAX = 59, MIN_MAX = 59, HOUR12_MIN = 1, HOUR12_MAX = 12.
  - The 7-bit field width typedef.
- One sub-module, btn_edge: 2-flop synchroniser plus rising-edge detector with synchronous reset, instantiated once for Mode_Btn and once for Inc_Btn.

Test Plan (all with CLK_HZ = 10):
- Reset, then 30 clock cycles in RUN -> Tick_1Hz pulses at cycles 10, 20 and 30 after reset release; Seconds = 3; all Blink_* = 0.
- Preload to 23:59:58 via set mode, return to RUN, wait 20 cycles -> 23:59:59, then 00:00:00 in one edge, with Tick_1Hz on both.
- Mode pressed once, then Inc held for 5 cycles -> state SET_H, Blink_H = 1, Hours advances by exactly 1, Minutes/Seconds unchanged; Inc in SET_M at Minutes = 59 -> Minutes = 0 and Hours unchanged.
- Mode and Inc rising in the same cycle while in RUN -> state SET_H, Hours unchanged; in SET_S, Mode -> RUN, and the first tick arrives exactly 10 cycles later.
- Reset asserted for one cycle while in SET_M at 12:34:56 -> next cycle shows 00:00:00, state RUN, all Blink_* = 0, Tick_1Hz = 0.
- With HOUR12_EN defined: reset -> Hours = 12, Pm = 0; run from 11:59:59 AM for one tick -> 12:00:00, Pm = 1; Inc in SET_H from 12 -> Hours = 1, Pm = 1.
